// File: rtl/pool_pkg.sv
// pool_pkg: shared pooling definitions (mode encodings, accumulator width helper).
// Used by the pooling engine and the feature-map writeback address generator.
package pool_pkg;

    // Pooling mode encodings; 2'd3 is reserved and handled as MAX.
    localparam logic [1:0] POOL_MAX = 2'd0;
    localparam logic [1:0] POOL_MIN = 2'd1;
    localparam logic [1:0] POOL_AVG = 2'd2;

    // Accumulator width that holds the sum of win samples of data_w bits without overflow.
    function automatic int unsigned ACC_W(input int unsigned data_w, input int unsigned win);
        return data_w + $clog2(win);
    endfunction

endpackage

// File: rtl/pool_reduce_alu.sv
// pool_reduce_alu: combinational reduction step for one pooling window.
// Ports:
//   acc        current accumulator (ACC_W bits)
//   sample     incoming sample (DATA_W bits)
//   mode       pooling mode (MAX/MIN/AVG, reserved = MAX)
//   sample_ext sample zero/sign-extended to accumulator width (window load value)
//   acc_next   accumulator after folding in the sample
module pool_reduce_alu
    import pool_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned WIN    = 4,
    parameter bit          SIGNED = 1'b0,
    localparam int unsigned AW    = ACC_W(DATA_W, WIN)
) (
    input  logic [AW-1:0]     acc,
    input  logic [DATA_W-1:0] sample,
    input  logic [1:0]        mode,
    output logic [AW-1:0]     sample_ext,
    output logic [AW-1:0]     acc_next
);

    localparam int unsigned EXT_W = AW - DATA_W;

    logic greater;
    logic lesser;

    // Extend, compare and fold; ties keep the accumulator value.
    always_comb begin
        sample_ext = {{EXT_W{SIGNED & sample[DATA_W-1]}}, sample};
        if (SIGNED) begin
            greater = $signed(sample_ext) > $signed(acc);
            lesser  = $signed(sample_ext) < $signed(acc);
        end else begin
            greater = sample_ext > acc;
            lesser  = sample_ext < acc;
        end
        acc_next = acc;
        case (mode)
            POOL_AVG: acc_next = acc + sample_ext;
            POOL_MIN: if (lesser)  acc_next = sample_ext;
            default:  if (greater) acc_next = sample_ext;
        endcase
    end

endmodule

// File: rtl/pool_window_engine.sv
// pool_window_engine: reduces each window of WIN consecutive samples to one result
// (max, min or truncating average) behind valid/ready handshakes.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   clr                  synchronous flush of the current window and any pending result
//   mode                 pooling mode, latched at the first sample of each window
//   in_valid/in_ready    sample handshake, in_data sample
//   out_valid/out_ready  result handshake, out_data pooled result (one-deep register)
//   win_cnt              samples already accepted in the current window
module pool_window_engine
    import pool_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned WIN    = 4,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic [1:0]              mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [$clog2(WIN)-1:0]  win_cnt
);

    localparam int unsigned AW       = ACC_W(DATA_W, WIN);
    localparam int unsigned LOG2_WIN = $clog2(WIN);
    localparam int unsigned CNT_W    = $clog2(WIN);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACC  = 1'b1;

    logic [0:0]        state, state_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [AW-1:0]     acc, acc_nxt;
    logic [1:0]        mode_q, mode_nxt, mode_norm;
    logic              out_valid_nxt;
    logic [DATA_W-1:0] out_data_nxt;
    logic              live;
    logic              in_xfer;
    logic              out_xfer;
    logic [AW-1:0]     sample_ext;
    logic [AW-1:0]     alu_acc;

    pool_reduce_alu #(
        .DATA_W (DATA_W),
        .WIN    (WIN),
        .SIGNED (SIGNED)
    ) u_alu (
        .acc        (acc),
        .sample     (in_data),
        .mode       (mode_q),
        .sample_ext (sample_ext),
        .acc_next   (alu_acc)
    );

    // Holds in_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) live <= 1'b0;
        else     live <= 1'b1;
    end

    assign in_ready  = live & (~out_valid | out_ready);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign mode_norm = (mode == POOL_MIN || mode == POOL_AVG) ? mode : POOL_MAX;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            win_cnt   <= '0;
            acc       <= '0;
            mode_q    <= POOL_MAX;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            win_cnt   <= cnt_nxt;
            acc       <= acc_nxt;
            mode_q    <= mode_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
        end
    end

    // Next-state: window load, accumulate, close; clr overrides every transfer.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = win_cnt;
        acc_nxt       = acc;
        mode_nxt      = mode_q;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        if (clr) begin
            state_nxt     = S_IDLE;
            cnt_nxt       = '0;
            acc_nxt       = '0;
            out_valid_nxt = 1'b0;
        end else begin
            if (out_xfer) out_valid_nxt = 1'b0;
            if (in_xfer) begin
                case (state)
                    S_IDLE: begin
                        mode_nxt  = mode_norm;
                        acc_nxt   = sample_ext;
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = S_ACC;
                    end
                    default: begin
                        acc_nxt = alu_acc;
                        if (win_cnt == CNT_W'(WIN - 1)) begin
                            cnt_nxt       = '0;
                            state_nxt     = S_IDLE;
                            out_valid_nxt = 1'b1;
                            // Average drops the low log2(WIN) bits: a floor divide in both signednesses.
                            out_data_nxt  = (mode_q == POOL_AVG) ? alu_acc[AW-1:LOG2_WIN]
                                                                 : alu_acc[DATA_W-1:0];
                        end else begin
                            cnt_nxt = win_cnt + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pool_window_engine.sv
// tb_pool_window_engine: scoreboard bench driving an unsigned and a signed engine in lockstep.
module tb_pool_window_engine;

    localparam int DW  = 16;
    localparam int WIN = 4;

    typedef logic [15:0] samp_q_t[$];

    logic        clk, rst, clr, in_valid, out_ready;
    logic [1:0]  mode;
    logic [15:0] in_data;
    logic        in_ready_u, in_ready_s, out_valid_u, out_valid_s;
    logic [15:0] out_data_u, out_data_s;
    logic [1:0]  win_cnt_u, win_cnt_s;

    int          checks = 0;
    int          failures = 0;
    int          rdy_mode = 0;
    int          nres_u = 0;
    logic [15:0] last_u = '0, last_s = '0;
    logic [1:0]  lmode = '0;
    bit          live;
    samp_q_t     cur;
    logic [15:0] qu[$];
    logic [15:0] qs[$];

    pool_window_engine #(.DATA_W(DW), .WIN(WIN), .SIGNED(1'b0)) u_dut_u (
        .clk(clk), .rst(rst), .clr(clr), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
        .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u),
        .win_cnt(win_cnt_u)
    );

    pool_window_engine #(.DATA_W(DW), .WIN(WIN), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .clr(clr), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .win_cnt(win_cnt_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Ready is expected from the first edge after reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) live <= 1'b0;
        else     live <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference pooling of a complete window from plain integer arithmetic.
    function automatic logic [15:0] ref_pool(input samp_q_t s, input logic [1:0] m, input bit sgn);
        longint v, acc, q;
        acc = 0;
        foreach (s[i]) begin
            v = sgn ? longint'($signed(s[i])) : longint'(s[i]);
            if (i == 0)       acc = v;
            else if (m == 1)  begin if (v < acc) acc = v; end
            else if (m == 2)  acc = acc + v;
            else              begin if (v > acc) acc = v; end
        end
        if (m == 2) begin
            q = acc / longint'(WIN);
            if (acc < 0 && (acc % longint'(WIN)) != 0) q = q - 1;
            acc = q;
        end
        return 16'(acc);
    endfunction

    // Downstream ready pattern: 0 = always ready, 1 = random, 2 = stalled.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: handshake checks and scoreboard pops.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                chk("rst_out_valid_u", 32'(out_valid_u), 32'd0);
                chk("rst_out_data_u",  32'(out_data_u),  32'd0);
                chk("rst_win_cnt_u",   32'(win_cnt_u),   32'd0);
                chk("rst_in_ready_u",  32'(in_ready_u),  32'd0);
                chk("rst_out_valid_s", 32'(out_valid_s), 32'd0);
                chk("rst_out_data_s",  32'(out_data_s),  32'd0);
            end else begin
                chk("in_ready_u",  32'(in_ready_u),  32'(live && (qu.size() == 0 || out_ready)));
                chk("in_ready_s",  32'(in_ready_s),  32'(live && (qs.size() == 0 || out_ready)));
                chk("out_valid_u", 32'(out_valid_u), 32'(qu.size() != 0));
                chk("out_valid_s", 32'(out_valid_s), 32'(qs.size() != 0));
                if (out_valid_u && out_ready) begin
                    if (qu.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL out_unexpected_u got=0x%0h exp=none", out_data_u);
                    end else begin
                        chk("out_data_u", 32'(out_data_u), 32'(qu.pop_front()));
                    end
                    last_u = out_data_u;
                    nres_u++;
                end
                if (out_valid_s && out_ready) begin
                    if (qs.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL out_unexpected_s got=0x%0h exp=none", out_data_s);
                    end else begin
                        chk("out_data_s", 32'(out_data_s), 32'(qs.pop_front()));
                    end
                    last_s = out_data_s;
                end
            end
        end
    end

    // Reference model: collects accepted samples and predicts each window result.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                cur.delete(); qu.delete(); qs.delete();
            end else begin
                chk("win_cnt_u", 32'(win_cnt_u), 32'(cur.size()));
                chk("win_cnt_s", 32'(win_cnt_s), 32'(cur.size()));
                if (clr) begin
                    cur.delete(); qu.delete(); qs.delete();
                end else if (in_valid && in_ready_u) begin
                    if (cur.size() == 0) lmode = mode;
                    cur.push_back(in_data);
                    if (cur.size() == WIN) begin
                        qu.push_back(ref_pool(cur, lmode, 1'b0));
                        qs.push_back(ref_pool(cur, lmode, 1'b1));
                        cur.delete();
                    end
                end
            end
        end
    end

    // Offer one sample from a falling edge until it is accepted.
    task automatic send(input logic [15:0] d, input logic [1:0] m);
        bit took;
        took = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        mode     = m;
        for (int g = 0; g < 2000 && !took; g++) begin
            #2;
            took = in_ready_u;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (!took) begin
            failures++;
            $display("FAIL send_timeout got=stalled exp=accepted data=0x%0h", d);
        end
    endtask

    task automatic send4(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input logic [15:0] d, input logic [1:0] m);
        send(a, m); send(b, m); send(c, m); send(d, m);
    endtask

    // Let pending results drain, then compare the last one seen.
    task automatic expect_last(input string name, input bit sgn, input logic [15:0] exp);
        repeat (3) @(negedge clk);
        #5;
        chk(name, 32'(sgn ? last_s : last_u), 32'(exp));
        @(negedge clk);
    endtask

    task automatic clr_pulse();
        in_valid = 1'b1;
        in_data  = 16'($urandom);
        clr      = 1'b1;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int n0;
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; mode = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Unsigned MAX
        send4(16'd3, 16'd9, 16'd2, 16'd7, 2'd0);
        expect_last("t1_max", 1'b0, 16'd9);
        chk("t1_win_cnt", 32'(win_cnt_u), 32'd0);

        // Signed MIN and AVG
        send4(16'hFFFB, 16'd4, 16'hFFF4, 16'd0, 2'd1);
        expect_last("t2_min_s", 1'b1, 16'hFFF4);
        send4(16'hFFFB, 16'd4, 16'hFFF4, 16'd0, 2'd2);
        expect_last("t2_avg_s", 1'b1, 16'hFFFC);

        // Unsigned AVG at full scale and with truncation
        send4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2'd2);
        expect_last("t3_avg_full", 1'b0, 16'hFFFF);
        send4(16'd1, 16'd2, 16'd2, 16'd2, 2'd2);
        expect_last("t3_avg_trunc", 1'b0, 16'd1);

        // Back-pressure: second window must wait for the first result to drain
        rdy_mode = 2;
        send4(16'd10, 16'd20, 16'd30, 16'd40, 2'd0);
        fork
            send4(16'd5, 16'd6, 16'd7, 16'd8, 2'd0);
            begin
                repeat (6) @(negedge clk);
                #2;
                chk("t4_in_ready_stall", 32'(in_ready_u), 32'd0);
                chk("t4_win_cnt_stall",  32'(win_cnt_u),  32'd0);
                rdy_mode = 0;
            end
        join
        expect_last("t4_second", 1'b0, 16'd8);

        // Mode change mid-window is ignored; next window picks it up
        send(16'd1, 2'd0); send(16'd8, 2'd1); send(16'd3, 2'd1); send(16'd4, 2'd1);
        expect_last("t5_mode_hold", 1'b0, 16'd8);
        send4(16'd9, 16'd3, 16'd7, 16'd5, 2'd1);
        expect_last("t5_next_min", 1'b0, 16'd3);

        // clr discards the partial window
        n0 = nres_u;
        send(16'd100, 2'd0); send(16'd200, 2'd0);
        clr_pulse();
        send4(16'd1, 16'd1, 16'd1, 16'd6, 2'd0);
        expect_last("t6_clr_result", 1'b0, 16'd6);
        chk("t6_result_count", 32'(nres_u - n0), 32'd1);

        // Reset in the middle of a window
        send(16'd50, 2'd0); send(16'd60, 2'd0);
        rst = 1'b1;
        #1;
        chk("t6_rst_out_data", 32'(out_data_u), 32'd0);
        chk("t6_rst_win_cnt",  32'(win_cnt_u),  32'd0);
        chk("t6_rst_in_ready", 32'(in_ready_u), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Randomized traffic with random back-pressure and occasional flushes
        rdy_mode = 1;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 59) == 0) clr_pulse();
            if ($urandom_range(0, 3) == 0) send(16'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            else                           send(16'($urandom), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        rdy_mode = 0;
        repeat (10) @(negedge clk);
        chk("end_drain_u", 32'(qu.size()), 32'd0);
        chk("end_drain_s", 32'(qs.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
